// File: rtl/md_unit_pkg.sv
// Shared core definitions for the multiply/divide unit: md_op encodings,
// controller state encodings and small decode helpers.
package md_unit_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_RSVD  = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/multu/div/divu into HI/LO,
// plus single-cycle mthi/mtlo. busy lets the hazard unit stall MD dependents.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;
  logic [31:0] div_b_s;
  logic [31:0] quot_s_s;
  logic [31:0] rem_s_s;
  logic [31:0] quot_u_s;
  logic [31:0] rem_u_s;
  logic        div_zero_s;
  logic        div_ovf_s;

  // Arithmetic on latched operands only; a zero divisor is replaced so the
  // divider never sees it, and the write-back is suppressed instead.
  always_comb begin
    prod_s_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u_s   = {32'd0, a_q} * {32'd0, b_q};
    div_zero_s = (b_q == 32'd0);
    div_ovf_s  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    div_b_s    = div_zero_s ? 32'd1 : b_q;
    if (div_ovf_s) begin
      quot_s_s = 32'h8000_0000;
      rem_s_s  = 32'd0;
    end else begin
      quot_s_s = $signed(a_q) / $signed(div_b_s);
      rem_s_s  = $signed(a_q) % $signed(div_b_s);
    end
    quot_u_s = a_q / div_b_s;
    rem_u_s  = a_q % div_b_s;
  end

  // Next-state: issue from IDLE, count down in RUN, retire at count 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d = ST_RUN;
              cnt_d   = is_div_op(md_op) ? CNT_DIV : CNT_MULT;
              op_d    = md_op;
              a_d     = rs_data;
              b_d     = rt_data;
            end
            MD_MTHI: hi_d = rs_data;
            MD_MTLO: lo_d = rs_data;
            default: begin
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          case (op_q)
            MD_MULT:  {hi_d, lo_d} = prod_s_s;
            MD_MULTU: {hi_d, lo_d} = prod_u_s;
            MD_DIV: begin
              if (!div_zero_s) begin
                hi_d = rem_s_s;
                lo_d = quot_s_s;
              end else begin
                hi_d = hi_q;
              end
            end
            MD_DIVU: begin
              if (!div_zero_s) begin
                hi_d = rem_u_s;
                lo_d = quot_u_s;
              end else begin
                hi_d = hi_q;
              end
            end
            default: begin
            end
          endcase
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      op_q    <= MD_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the pipelined MIPS32 core, sitting in the EX stage directly downstream of `grf`. It consumes the (forwarded) `read_data1`/`read_data2` register operands, computes `mult`/`multu`/`div`/`divu` over a fixed multi-cycle latency, and holds the results in the HI/LO registers. `mthi`/`mtlo` write those registers directly. The HI/LO contents return to `grf` through the pipeline via `mfhi`/`mflo`. The block exports `busy` so the hazard unit can stall dependent MD instructions.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high. Clears all state.
- `start` in 1: single-cycle request; the op is taken only when `busy`=0.
- `md_op` in 3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is reserved.
- `rs_data` in 32: operand A (dividend / multiplicand / mthi-mtlo source).
- `rt_data` in 32: operand B (divisor / multiplier).
- `busy` out 1: high while a mult/div is in flight.
- `hi` out 32: HI register, a direct register output.
- `lo` out 32: LO register, a direct register output.

## Operation
- State machine: IDLE, RUN.
  - IDLE → RUN on `start`=1 with `md_op` in 1..4:
    - latch operands and op;
    - load the down-counter with `MULT_CYCLES` or `DIV_CYCLES`.
  - RUN:
    - decrement the counter each cycle;
    - at count 1, write the results to HI/LO and return to IDLE.
- Results are computed on the latched operands, never on live inputs, so the pipeline may change `rs_data`/`rt_data` freely after issue.
- mult: signed 32×32 → 64-bit product; HI = [63:32], LO = [31:0].
- multu: as mult, unsigned.
- div (signed): LO = quotient, truncated toward zero; HI = remainder, carrying the dividend's sign.
- divu: unsigned quotient to LO, remainder to HI.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (div or divu): full latency still elapses, then HI and LO are left unchanged.
- mthi / mtlo:
  - taken only when `busy`=0;
  - update HI (resp. LO) from `rs_data` at the next edge;
  - `busy` stays 0.
- `start` while `busy`=1 is ignored: no latch and no state change. The hazard unit guarantees this does not occur in legal flow.
- `start` with `md_op` 0 or 7 is a no-op.
- Reset, including mid-operation: HI = LO = 0, counter = 0, state IDLE, `busy` = 0. The in-flight op is discarded.

## Timing
- Issue at edge T (`start`=1, `busy`=0):
  - `busy`=1 during cycles T+1 … T+N, where N = `MULT_CYCLES` or `DIV_CYCLES`;
  - HI/LO take the new values at the edge ending cycle T+N;
  - `busy`=0 from cycle T+N+1.
- A new `start` may be accepted in cycle T+N+1, back-to-back with no extra gap.
- mthi/mtlo: 1-cycle write, with the new value visible in the cycle after issue.
- `hi`/`lo` outputs are direct register outputs and hold their old values throughout RUN.

## Structure
- The `md_op` encodings (MD_NONE … MD_MTLO) go in the shared core definitions package used by the controller and the hazard unit.
- Single module with no sub-modules. The arithmetic is behavioural (`*`, `/`, `%` on `$signed`/unsigned latched operands), evaluated only when the counter reaches 1.

## Test plan
- Reset during mult:
  - stimulus: `mult` 3 × 4; assert `reset` in cycle T+2;
  - required: `busy`=0 immediately, HI=LO=0, and no late write at T+5.
- mult, signed negative:
  - stimulus: rs=0xFFFFFFFE (-2), rt=3;
  - required: `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu, unsigned:
  - stimulus: rs=0xFFFFFFFF, rt=0xFFFFFFFF;
  - required: HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- div, signed:
  - stimulus: -7 ÷ 2;
  - required: after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- div edge cases:
  - 0x80000000 ÷ -1 gives LO=0x80000000, HI=0.
  - divu 5 ÷ 0 with prior HI=0x11, LO=0x22: HI/LO stay unchanged after 10 cycles.
- mthi, ignored start, back-to-back:
  - mthi 0xDEADBEEF: HI updates next cycle, `busy` never rises.
  - `start` with mtlo while a div is busy: LO is unaffected.
  - A mult issued in the cycle `busy` falls is accepted.
